// File: rtl/otter_mem_arbiter_pkg.sv
// Shared definitions for the OTTER memory arbiter.
//   arb_state_t : controller states (IDLE / HOLD / WAIT)
//   arb_owner_t : which requester owns the memory port (FETCH / DATA)
package otter_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,  // no transaction; arbitrate and present request
        ARB_HOLD = 2'd1,  // request presented, waiting for m_gnt
        ARB_WAIT = 2'd2   // request granted, waiting for m_rvalid
    } arb_state_t;

    typedef enum logic {
        ARB_OWN_FETCH = 1'b0,
        ARB_OWN_DATA  = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/otter_arb_prio.sv
// Requester selection for the OTTER memory arbiter.
// Data has priority, but after MAX_D_STREAK consecutive data grants with a
// fetch pending, fetch wins the next arbitration.
//   clk, rst_n   : clock, synchronous active-low reset
//   i_req, d_req : fetch / data requests
//   i_gnt, d_gnt : grant events from the top (update the streak counter)
//   sel          : selected owner, combinational
module otter_arb_prio
    import otter_mem_arbiter_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_req,
    input  logic       d_req,
    input  logic       i_gnt,
    input  logic       d_gnt,
    output arb_owner_t sel
);

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);

    logic [SW-1:0] streak;
    logic          starved;

    assign starved = i_req && (streak == STREAK_MAX);

    always_comb begin
        // NOTE: default first so every path assigns sel and no latch is inferred.
        sel = ARB_OWN_DATA;
        if (d_req && !starved) begin
            sel = ARB_OWN_DATA;
        end else if (i_req) begin
            sel = ARB_OWN_FETCH;
        end
    end

    // Streak counts data grants only while fetch is actually waiting; any
    // cycle without a fetch request means nobody is being starved.
    // NOTE: reset is sampled on the clock edge (synchronous), not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (!i_req || i_gnt) begin
            // NOTE: non-blocking assignment for all registered state.
            streak <= '0;
        end else if (d_gnt && (streak != STREAK_MAX)) begin
            streak <= streak + 1'b1;
        end
    end

endmodule

// File: rtl/otter_mem_arbiter.sv
// Shares one single-ported memory between the OTTER fetch and data requesters.
// One transaction outstanding at a time; data has priority with a bounded
// starvation guard for fetch (see otter_arb_prio).
//   i_*  : fetch requester (req/addr in, gnt/rvalid/rdata out)
//   d_*  : data requester (req/we/strb/addr/wdata in, gnt/rvalid/rdata out)
//   m_*  : memory side (req/we/strb/addr/wdata out, gnt/rvalid/rdata in)
module otter_mem_arbiter
    import otter_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_strb,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_strb,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_gnt,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata
);

    arb_state_t state, state_n;
    arb_owner_t owner, owner_n;
    arb_owner_t sel;
    arb_owner_t bus_owner;

    otter_arb_prio #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_prio (
        .clk  (clk),
        .rst_n(rst_n),
        .i_req(i_req),
        .d_req(d_req),
        .i_gnt(i_gnt),
        .d_gnt(d_gnt),
        .sel  (sel)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ARB_IDLE;
            owner <= ARB_OWN_DATA;
        end else begin
            state <= state_n;
            owner <= owner_n;
        end
    end

    always_comb begin
        state_n   = state;
        owner_n   = owner;
        bus_owner = owner;
        m_req     = 1'b0;
        m_we      = 1'b0;
        m_strb    = '0;
        m_addr    = '0;
        m_wdata   = '0;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        i_rvalid  = 1'b0;
        d_rvalid  = 1'b0;
        i_rdata   = '0;
        d_rdata   = '0;

        unique case (state)
            ARB_IDLE: begin
                // Live selection gives zero added latency; the owner is
                // latched so HOLD/WAIT keep serving the same requester.
                bus_owner = sel;
                owner_n   = sel;
                m_req     = i_req | d_req;
                if (m_req) begin
                    state_n = m_gnt ? ARB_WAIT : ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                // Kept asserted even if the owner drops its request.
                m_req = 1'b1;
                if (m_gnt) begin
                    state_n = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (m_rvalid) begin
                    if (owner == ARB_OWN_FETCH) begin
                        i_rvalid = 1'b1;
                        i_rdata  = m_rdata;
                    end else begin
                        d_rvalid = 1'b1;
                        d_rdata  = m_rdata;
                    end
                    state_n = ARB_IDLE;
                end
            end
            default: state_n = ARB_IDLE;
        endcase

        // Bus is zero whenever no request is presented; fetch never writes.
        if (m_req) begin
            if (bus_owner == ARB_OWN_FETCH) begin
                m_addr = i_addr;
                i_gnt  = m_gnt;
            end else begin
                m_we    = d_we;
                m_strb  = d_strb;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                d_gnt   = m_gnt;
            end
        end
    end

endmodule

// File: tb/tb_otter_mem_arbiter.sv
module tb_otter_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we;
    logic [SW-1:0] d_strb;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_req, m_we;
    logic [SW-1:0] m_strb;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic          m_gnt, m_rvalid;
    logic [DW-1:0] m_rdata;

    otter_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_strb(d_strb), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_strb(m_strb), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_fetch;
        logic [DW-1:0] data;
    } resp_t;

    resp_t resp_q[$];
    resp_t mon_r;
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_resp(input logic is_fetch, input logic [DW-1:0] data);
        resp_t r;
        r.is_fetch = is_fetch;
        r.data     = data;
        resp_q.push_back(r);
    endtask

    // Drops requests, waits one WAIT cycle, then delivers the response.
    task automatic respond(input logic is_fetch, input logic [DW-1:0] data);
        i_req = 1'b0;
        d_req = 1'b0;
        m_gnt = 1'b0;
        tick();
        m_rvalid = 1'b1;
        m_rdata  = data;
        push_resp(is_fetch, data);
        tick();
        m_rvalid = 1'b0;
        m_rdata  = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mreq"}, {m_req, m_we, m_strb}, '0);
        check({tag, "_mbus"}, {m_addr, m_wdata}, '0);
        check({tag, "_gnt_rv"}, {i_gnt, d_gnt, i_rvalid, d_rvalid}, '0);
        check({tag, "_rdata"}, {i_rdata, d_rdata}, '0);
    endtask

    // Response scoreboard: pops whenever the DUT forwards a response.
    always @(negedge clk) begin
        check("gnt_exclusive", {63'd0, i_gnt & d_gnt}, 64'd0);
        if (i_rvalid || d_rvalid) begin
            if (resp_q.size() == 0) begin
                check("unexpected_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
            end else begin
                mon_r = resp_q.pop_front();
                check("rvalid_owner", {62'd0, i_rvalid, d_rvalid},
                      mon_r.is_fetch ? 64'd2 : 64'd1);
                check("rdata", mon_r.is_fetch ? i_rdata : d_rdata, mon_r.data);
            end
        end else begin
            check("rdata_idle", {i_rdata, d_rdata}, 64'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic cont_exp[10];
    int   k;
    logic pend;

    initial begin
        rst_n = 1'b0; i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_strb = '0; d_addr = '0; d_wdata = '0;
        m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        tick();

        // Fetch only, immediate grant, response two cycles later.
        i_req = 1'b1; i_addr = 32'h100; m_gnt = 1'b1;
        @(negedge clk);
        check("f_gnt", {i_gnt, d_gnt}, 2'b10);
        check("f_addr", m_addr, 32'h100);
        check("f_we_strb", {m_we, m_strb}, '0);
        tick();
        i_req = 1'b0; m_gnt = 1'b0;
        @(negedge clk);
        check("f_wait_mreq", m_req, 1'b0);
        tick();
        m_rvalid = 1'b1; m_rdata = 32'hDEADBEEF;
        push_resp(1'b1, 32'hDEADBEEF);
        tick();
        m_rvalid = 1'b0; m_rdata = '0;
        check("f_resp_done", resp_q.size(), 0);

        // Store with grant delayed 3 cycles.
        d_req = 1'b1; d_we = 1'b1; d_strb = 4'h3; d_addr = 32'h2004; d_wdata = 32'h1234;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("s_hold_req", {m_req, m_we, m_strb, d_gnt, i_gnt}, {1'b1, 1'b1, 4'h3, 2'b00});
            check("s_hold_bus", {m_addr, m_wdata}, {32'h2004, 32'h1234});
            tick();
        end
        m_gnt = 1'b1;
        @(negedge clk);
        check("s_gnt", {d_gnt, i_gnt}, 2'b10);
        check("s_gnt_addr", m_addr, 32'h2004);
        tick();
        d_we = 1'b0; d_strb = '0;
        respond(1'b0, 32'hAAAA5555);
        check("s_resp_done", resp_q.size(), 0);

        // Contention: both requesters high, memory grants always, 1-cycle response.
        cont_exp = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        m_gnt = 1'b1;
        k = 0; pend = 1'b0;
        for (int cyc = 0; cyc < 60 && k < 10; cyc++) begin
            m_rvalid = pend;
            m_rdata  = pend ? (32'hC0DE0000 + 32'(k)) : '0;
            if (pend) push_resp(cont_exp[k-1], 32'hC0DE0000 + 32'(k));
            pend = 1'b0;
            @(negedge clk);
            if (i_gnt || d_gnt) begin
                check("cont_order", {63'd0, i_gnt}, {63'd0, cont_exp[k]});
                check("cont_addr", m_addr, cont_exp[k] ? 32'h200 : 32'h3000);
                pend = 1'b1;
                k++;
            end
            tick();
        end
        check("cont_grants", k, 10);
        i_req = 1'b0; d_req = 1'b0; m_gnt = 1'b0;
        if (pend) begin
            m_rvalid = 1'b1;
            m_rdata  = 32'hC0DE0000 + 32'(k);
            push_resp(cont_exp[k-1], 32'hC0DE0000 + 32'(k));
            tick();
        end
        m_rvalid = 1'b0; m_rdata = '0;
        tick();
        check("cont_resp_done", resp_q.size(), 0);

        // HOLD freeze: fetch pending, data rises next cycle.
        i_req = 1'b1; i_addr = 32'h140; m_gnt = 1'b0;
        tick();
        d_req = 1'b1; d_we = 1'b1; d_strb = 4'hF; d_addr = 32'h3300; d_wdata = 32'h77;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("h_addr", m_addr, 32'h140);
            check("h_we_gnt", {m_req, m_we, m_strb, i_gnt, d_gnt}, {1'b1, 7'd0});
            tick();
        end
        m_gnt = 1'b1;
        @(negedge clk);
        check("h_gnt", {i_gnt, d_gnt}, 2'b10);
        tick();
        i_req = 1'b0; m_gnt = 1'b0;
        @(negedge clk);
        check("h_wait_mreq", {m_req, d_gnt}, 2'b00);
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h5A5A0001;
        push_resp(1'b1, 32'h5A5A0001);
        tick();
        m_rvalid = 1'b0; m_rdata = '0; m_gnt = 1'b1;
        @(negedge clk);
        check("h_next_d_gnt", {i_gnt, d_gnt}, 2'b01);
        check("h_next_d_addr", m_addr, 32'h3300);
        tick();
        d_we = 1'b0; d_strb = '0; d_wdata = '0;
        respond(1'b0, 32'h0BADF00D);
        check("h_resp_done", resp_q.size(), 0);

        // Reset while in WAIT; response arrives after release and is dropped.
        i_req = 1'b1; i_addr = 32'h180; m_gnt = 1'b1;
        @(negedge clk);
        check("r_gnt", {i_gnt, d_gnt}, 2'b10);
        tick();
        i_req = 1'b0; m_gnt = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_all_zero("r_after");
        tick();
        m_rvalid = 1'b1; m_rdata = 32'h00000BAD;
        @(negedge clk);
        check("r_dropped", {i_rvalid, d_rvalid}, 2'b00);
        tick();
        m_rvalid = 1'b0; m_rdata = '0;
        d_req = 1'b1; d_addr = 32'h2100; m_gnt = 1'b1;
        @(negedge clk);
        check("r_idle_gnt", {i_gnt, d_gnt}, 2'b01);
        tick();
        respond(1'b0, 32'h11112222);
        check("r_resp_done", resp_q.size(), 0);

        // Stray response in IDLE with no requests.
        m_rvalid = 1'b1; m_rdata = 32'hFEEDFACE;
        @(negedge clk);
        check("st_no_rvalid", {i_rvalid, d_rvalid, m_req}, 3'b000);
        tick();
        m_rvalid = 1'b0; m_rdata = '0;
        i_req = 1'b1; i_addr = 32'h1C0; m_gnt = 1'b1;
        @(negedge clk);
        check("st_idle_gnt", {i_gnt, d_gnt}, 2'b10);
        tick();
        respond(1'b1, 32'h33334444);
        check("st_resp_done", resp_q.size(), 0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
